// File: rtl/lightpipe_pkg.sv
// Shared ADAT framing constants and types, used by both the transmitter and
// the receiver so the two ends of the link agree on the frame layout.
package lightpipe_pkg;

  localparam int FRAME_BITS  = 256;  // bits per ADAT frame
  localparam int SYNC_ZEROS  = 10;   // leading run of zeros (sync)
  localparam int USER_START  = 11;   // user separator '1'; user nibble follows
  localparam int DATA_START  = 16;   // first bit of channel 0
  localparam int CH_BITS     = 30;   // 6 nibbles x (separator + 4 data bits)
  localparam int NIBBLE_BITS = 5;    // separator + 4 data bits
  localparam int CHANNELS    = 8;
  localparam int WCLK_FALL   = 128;  // word clock falls half way through a frame

  typedef logic [23:0] adat_sample_t;

endpackage

// File: rtl/lightpipe_xmit_nrzi.sv
// NRZI line encoder: a '1' toggles the line, a '0' holds it. Inverse of the
// receiver's nrzi_decoder.
module nrzi_encoder #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic mclk,
  input  logic rst,
  input  logic bit_strobe,
  input  logic raw_bit,
  output logic line
);

  logic line_q, line_d;

  // Toggle the line for every '1' presented on a bit strobe.
  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    line_d = line_q;
    if (bit_strobe) line_d = line_q ^ raw_bit;
  end

  // Line register; reset forces the idle level so the receiver sees no edges.
  always_ff @(posedge mclk or negedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst) line_q <= IDLE_LEVEL;
    else      line_q <= line_d;
  end

  assign line = line_q;

endmodule

// File: rtl/lightpipe_xmit.sv
// ADAT (Lightpipe) transmitter: frame counter, per-frame input snapshot,
// raw-bit multiplexer and word clock; the NRZI stage is a sub-module.
module lightpipe_xmit
  import lightpipe_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         bit_en,
  input  logic         en,
  input  adat_sample_t word0,
  input  adat_sample_t word1,
  input  adat_sample_t word2,
  input  adat_sample_t word3,
  input  adat_sample_t word4,
  input  adat_sample_t word5,
  input  adat_sample_t word6,
  input  adat_sample_t word7,
  input  logic [3:0]   user,
  output logic         adat,
  output logic         wclk,
  output logic         frame_start
);

  adat_sample_t word_in [CHANNELS];
  adat_sample_t snap_q  [CHANNELS];
  adat_sample_t snap_d  [CHANNELS];
  logic [3:0]   user_q, user_d;
  logic [7:0]   bitpos_q, bitpos_d;
  logic         wclk_q, wclk_d;
  logic         frame_start_q, frame_start_d;

  logic         step;
  logic         raw_bit;
  logic [7:0]   data_off;
  logic [2:0]   ch;
  logic [4:0]   off;
  logic [2:0]   nib;
  logic [2:0]   sub;
  logic [4:0]   bit_idx;

  assign word_in = '{word0, word1, word2, word3, word4, word5, word6, word7};
  assign step    = bit_en && en;

  // Map the current bit position to its raw (pre-NRZI) bit value.
  always_comb begin
    data_off = bitpos_q - 8'(DATA_START);
    ch       = 3'(data_off / 8'(CH_BITS));
    off      = 5'(data_off % 8'(CH_BITS));
    nib      = 3'(off / 5'(NIBBLE_BITS));
    sub      = 3'(off % 5'(NIBBLE_BITS));
    // Sample bit sent at sub-slot m of nibble n is bit 23-4n-(m-1).
    bit_idx  = 5'd24 - {nib, 2'b00} - {2'b00, sub};
    raw_bit  = 1'b0;
    if (bitpos_q < 8'(SYNC_ZEROS))      raw_bit = 1'b0;
    else if (bitpos_q <= 8'(USER_START)) raw_bit = 1'b1;
    else if (bitpos_q < 8'(DATA_START))  raw_bit = user_q[~bitpos_q[1:0]];  // 12..15 -> user[3..0]
    else if (sub == 3'd0)                raw_bit = 1'b1;
    else                                 raw_bit = snap_q[ch][bit_idx];
  end

  // Frame sequencing: counter, snapshot at bit 0, word clock, frame pulse.
  always_comb begin
    bitpos_d      = bitpos_q;
    wclk_d        = wclk_q;
    frame_start_d = 1'b0;
    snap_d        = snap_q;
    user_d        = user_q;
    if (bit_en) begin
      if (en) begin
        bitpos_d = bitpos_q + 8'd1;  // natural 8-bit wrap 255 -> 0
        if (bitpos_q == 8'd0) begin
          wclk_d        = 1'b1;
          frame_start_d = 1'b1;
          snap_d        = word_in;
          user_d        = user;
        end else if (bitpos_q == 8'(WCLK_FALL)) begin
          wclk_d = 1'b0;
        end
      end else begin
        // Disabled: abandon the frame, line stays quiet.
        bitpos_d = 8'd0;
        wclk_d   = 1'b0;
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      bitpos_q      <= 8'd0;
      wclk_q        <= 1'b0;
      frame_start_q <= 1'b0;
      user_q        <= 4'd0;
      // NOTE: this small register file is reset (unlike a RAM) so any frame sent
      // before a snapshot carries known zeros.
      snap_q        <= '{default: '0};
    end else begin
      bitpos_q      <= bitpos_d;
      wclk_q        <= wclk_d;
      frame_start_q <= frame_start_d;
      user_q        <= user_d;
      snap_q        <= snap_d;
    end
  end

  nrzi_encoder #(.IDLE_LEVEL(IDLE_LEVEL)) u_nrzi (
    .mclk       (mclk),
    .rst        (rst),
    .bit_strobe (step),
    .raw_bit    (raw_bit),
    .line       (adat)
  );

  assign wclk        = wclk_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lightpipe_xmit.sv
// Self-checking bench for lightpipe_xmit: a frame-level reference model builds
// each 256-bit frame from the inputs and tracks the expected line level.
module tb_lightpipe_xmit;
  import lightpipe_pkg::*;

  logic         mclk = 1'b0;
  logic         rst;
  logic         bit_en;
  logic         en;
  adat_sample_t word [8];
  logic [3:0]   user;
  logic         adat;
  logic         wclk;
  logic         frame_start;

  always #5 mclk = ~mclk;

  lightpipe_xmit #(.IDLE_LEVEL(1'b0)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .bit_en      (bit_en),
    .en          (en),
    .word0       (word[0]),
    .word1       (word[1]),
    .word2       (word[2]),
    .word3       (word[3]),
    .word4       (word[4]),
    .word5       (word[5]),
    .word6       (word[6]),
    .word7       (word[7]),
    .user        (user),
    .adat        (adat),
    .wclk        (wclk),
    .frame_start (frame_start)
  );

  int   tests_run  = 0;
  int   fail_count = 0;

  // Reference model state
  int   m_pos;
  logic m_adat;
  logic m_wclk;
  logic m_frame  [256];
  logic dec_bits [256];

  // Line statistics gathered every mclk
  int   cyc, trans, wclk_hi, last_fs, fs_period;
  logic prev_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
    cyc++;
    if (adat !== prev_line) trans++;
    prev_line = adat;
    if (wclk === 1'b1) wclk_hi++;
    if (frame_start === 1'b1) begin
      fs_period = cyc - last_fs;
      last_fs   = cyc;
    end
  endtask

  task automatic clear_stats();
    trans   = 0;
    wclk_hi = 0;
  endtask

  // Frame as the wire sees it: sync, separator, user, then 8 x 6 nibbles.
  task automatic build_frame();
    int idx;
    idx = 0;
    for (int i = 0; i < 10; i++) m_frame[idx++] = 1'b0;
    m_frame[idx++] = 1'b1;
    m_frame[idx++] = 1'b1;
    for (int b = 3; b >= 0; b--) m_frame[idx++] = user[b];
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 6; n++) begin
        m_frame[idx++] = 1'b1;
        for (int b = 0; b < 4; b++) m_frame[idx++] = word[k][23 - 4*n - b];
      end
    end
  endtask

  // One bit period: a single-cycle strobe followed by gap idle cycles.
  task automatic strobe(input int gap);
    logic exp_fs;
    logic prev;
    int   sent_pos;
    prev     = adat;
    exp_fs   = 1'b0;
    sent_pos = -1;
    if (en) begin
      if (m_pos == 0) begin
        build_frame();
        exp_fs = 1'b1;
        m_wclk = 1'b1;
      end else if (m_pos == 128) begin
        m_wclk = 1'b0;
      end
      m_adat   = m_adat ^ m_frame[m_pos];
      sent_pos = m_pos;
      m_pos    = (m_pos + 1) % 256;
    end else begin
      m_pos  = 0;
      m_wclk = 1'b0;
    end
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    check("adat", adat, m_adat);
    check("wclk", wclk, m_wclk);
    check("frame_start", frame_start, exp_fs);
    if (sent_pos >= 0) dec_bits[sent_pos] = adat ^ prev;
    repeat (gap) begin
      tick();
      check("adat_gap", adat, m_adat);
      check("wclk_gap", wclk, m_wclk);
      check("frame_start_gap", frame_start, 1'b0);
    end
  endtask

  function automatic adat_sample_t dec_word(input int k);
    adat_sample_t w;
    for (int n = 0; n < 6; n++)
      for (int b = 0; b < 4; b++)
        w[23 - 4*n - b] = dec_bits[16 + 30*k + 5*n + 1 + b];
    return w;
  endfunction

  function automatic logic [3:0] dec_user();
    return {dec_bits[12], dec_bits[13], dec_bits[14], dec_bits[15]};
  endfunction

  function automatic logic [29:0] dec_channel(input int k);
    logic [29:0] v;
    for (int i = 0; i < 30; i++) v[29 - i] = dec_bits[16 + 30*k + i];
    return v;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) word[i] = adat_sample_t'($urandom);
    user = 4'($urandom);
  endtask

  task automatic check_roundtrip(input adat_sample_t exp_w [8], input logic [3:0] exp_u);
    for (int i = 0; i < 8; i++) check($sformatf("roundtrip_word%0d", i), dec_word(i), exp_w[i]);
    check("roundtrip_user", dec_user(), exp_u);
  endtask

  initial begin
    adat_sample_t saved_w [8];
    logic [3:0]   saved_u;
    logic [34:0]  got35;
    logic [34:0]  exp35;
    logic [29:0]  idle_ch;

    exp35   = 35'b11010_110001000010000100001000010001;
    idle_ch = 30'b100001000010000100001000010000;
    cyc = 0; trans = 0; wclk_hi = 0; last_fs = 0; fs_period = 0;
    rst = 1'b1; bit_en = 1'b0; en = 1'b0; user = 4'd0;
    for (int i = 0; i < 8; i++) word[i] = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_adat", adat, 1'b0);
    check("reset_wclk", wclk, 1'b0);
    check("reset_frame_start", frame_start, 1'b0);
    prev_line = adat;
    tick(); tick();
    #2 rst = 1'b1;
    m_pos = 0; m_adat = 1'b0; m_wclk = 1'b0;
    en = 1'b1;

    // All-zero words, strobe every 4 mclk: two frames, stats on the second.
    repeat (256) strobe(3);
    clear_stats();
    repeat (256) strobe(3);
    check("zero_transitions", trans, 50);
    check("zero_wclk_high", wclk_hi, 512);
    check("zero_fs_period", fs_period, 1024);
    for (int k = 0; k < 8; k++) check($sformatf("zero_ch%0d", k), dec_channel(k), idle_ch);

    // Reset arriving mid-frame at bit position 100.
    repeat (100) strobe(3);
    #2 rst = 1'b0;
    #1;
    check("midreset_adat", adat, 1'b0);
    check("midreset_wclk", wclk, 1'b0);
    check("midreset_frame_start", frame_start, 1'b0);
    tick();
    #3 rst = 1'b1;
    m_pos = 0; m_adat = 1'b0; m_wclk = 1'b0;
    repeat (256) strobe(3);

    // word0 = 800001, user = A.
    word[0] = 24'h800001;
    user    = 4'hA;
    repeat (256) strobe(0);
    for (int i = 0; i < 35; i++) got35[34 - i] = dec_bits[11 + i];
    check("w800001_bits11_45", got35, exp35);
    for (int k = 1; k < 8; k++) check($sformatf("w800001_ch%0d", k), dec_channel(k), idle_ch);

    // Snapshot: word3 changes mid-frame, only the next frame picks it up.
    word[0] = '0; user = 4'd0; word[3] = 24'h123456;
    repeat (50) strobe(0);
    word[3] = 24'hABCDEF;
    repeat (206) strobe(0);
    check("snap_current", dec_word(3), 24'h123456);
    repeat (256) strobe(0);
    check("snap_next", dec_word(3), 24'hABCDEF);

    // en dropped at bit position 77 for 300 bit periods.
    repeat (77) strobe(1);
    en = 1'b0;
    strobe(1);
    clear_stats();
    repeat (299) strobe(1);
    check("en_off_transitions", trans, 0);
    check("en_off_wclk_high", wclk_hi, 0);
    en = 1'b1;
    randomize_inputs();
    saved_w = word; saved_u = user;
    repeat (256) strobe(1);
    check_roundtrip(saved_w, saved_u);

    // Back-to-back strobes for 3 frames; inputs scrambled after each snapshot.
    for (int f = 0; f < 3; f++) begin
      randomize_inputs();
      saved_w = word; saved_u = user;
      strobe(0);
      randomize_inputs();
      repeat (255) strobe(0);
      check_roundtrip(saved_w, saved_u);
    end
    strobe(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
